// File: rtl/cdb_scheduler_pkg.sv
// ============================================================================
// cdb_scheduler_pkg : shared widths, empty-tag constant and clog2 helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package cdb_scheduler_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;
  localparam int EMPTY_TAG  = 0;
  localparam int WAIT_W     = 4;

  typedef logic [WAIT_W-1:0] wait_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_scheduler_rr_arbiter.sv
// ============================================================================
// cdb_scheduler_rr_arbiter : combinational round-robin arbiter with forced
// lowest-index priority override. Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] force_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] rot;
  int                 sel;
  int                 pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    sel     = -1;
    pos     = 0;
    // rot[k] is the request sitting k places after the pointer
    rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
    if (enable_i) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (force_i[i] && req_i[i]) sel = i;
      end
      if (sel < 0) begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (rot[k]) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            sel = pos;
          end
        end
      end
      if (sel >= 0) begin
        idx_o = SRC_W'(sel);
        for (int i = 0; i < NUM_REQ; i++) begin
          grant_o[i] = (sel == i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_scheduler.sv
// ============================================================================
// cdb_scheduler : shares the common data bus between functional units with
// round-robin, starvation override, flush kill and registered broadcast.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cdb_scheduler
  import cdb_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int SRC_W    = 2,
  parameter int MAX_WAIT = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      cdb_valid_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [SRC_W-1:0]          cdb_src_o
);

  if ((SRC_W != clog2(NUM_REQ)) || (NUM_REQ < 2) || (NUM_REQ > 8) ||
      (MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_params
    $error("cdb_scheduler: illegal parameter combination");
  end

  localparam wait_t MAX_WAIT_C = wait_t'(MAX_WAIT);

  wait_t              wait_q [NUM_REQ];
  wait_t              wait_d [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] force_vec;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               arb_en;
  logic [DATA_W-1:0]  sel_data;
  logic [TAG_W-1:0]   sel_tag;

  logic               cdb_valid_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [SRC_W-1:0]   cdb_src_q;

  // Gating with rst_ni keeps req_ready low for the whole reset window
  assign arb_en = rst_ni & ~flush_i;

  always_comb begin
    force_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      force_vec[i] = req_valid_i[i] && (wait_q[i] == MAX_WAIT_C);
    end
  end

  cdb_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .force_i  (force_vec),
    .enable_i (arb_en),
    .grant_o  (grant),
    .idx_o    (grant_idx)
  );

  assign grant_any   = |grant;
  assign req_ready_o = grant;

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = req_data_i[i*DATA_W +: DATA_W];
        sel_tag  = req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_d[i] = wait_q[i];
      if (flush_i || !req_valid_i[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != MAX_WAIT_C) begin
        wait_d[i] = wait_q[i] + wait_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= TAG_W'(EMPTY_TAG);
      cdb_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant_any;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
      if (grant_any) begin
        cdb_data_q <= sel_data;
        cdb_tag_q  <= sel_tag;
        cdb_src_q  <= grant_idx;
      end
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_scheduler.sv
// ============================================================================
// tb_cdb_scheduler : two schedulers (MAX_WAIT 3 and 1) driven in parallel and
// compared against a rule-level reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cdb_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;

  logic [N-1:0]  rdy [2];
  logic          cv  [2];
  logic [DW-1:0] cd  [2];
  logic [TW-1:0] ct  [2];
  logic [SW-1:0] cs  [2];

  always #5 clk = ~clk;

  cdb_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .SRC_W(SW), .MAX_WAIT(3)) u_dut_w3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_data_i(req_data), .req_tag_i(req_tag), .req_ready_o(rdy[0]),
    .cdb_valid_o(cv[0]), .cdb_data_o(cd[0]), .cdb_tag_o(ct[0]), .cdb_src_o(cs[0])
  );

  cdb_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .SRC_W(SW), .MAX_WAIT(1)) u_dut_w1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_valid_i(req_valid),
    .req_data_i(req_data), .req_tag_i(req_tag), .req_ready_o(rdy[1]),
    .cdb_valid_o(cv[1]), .cdb_data_o(cd[1]), .cdb_tag_o(ct[1]), .cdb_src_o(cs[1])
  );

  int n_checks = 0;
  int n_err    = 0;

  int            max_wait [2] = '{3, 1};
  int            m_ptr    [2];
  int            m_wait   [2][N];
  logic          m_valid  [2];
  logic [DW-1:0] m_data   [2];
  logic [TW-1:0] m_tag    [2];
  int            m_src    [2];
  int            g_now    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starved requesters (lowest index first) beat the rotation; otherwise scan from the pointer.
  function automatic int model_grant(input int u);
    if (flush) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && m_wait[u][i] >= max_wait[u]) return i;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr[u] + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_ptr[u]   = 0;
      m_valid[u] = 1'b0;
      m_data[u]  = '0;
      m_tag[u]   = '0;
      m_src[u]   = 0;
      g_now[u]   = -1;
      for (int i = 0; i < N; i++) m_wait[u][i] = 0;
    end
  endtask

  task automatic model_clock(input int u, input int g);
    for (int i = 0; i < N; i++) begin
      if (flush || !req_valid[i] || i == g) m_wait[u][i] = 0;
      else if (m_wait[u][i] < max_wait[u]) m_wait[u][i] = m_wait[u][i] + 1;
    end
    if (g >= 0) begin
      m_valid[u] = 1'b1;
      m_data[u]  = req_data[g*DW +: DW];
      m_tag[u]   = req_tag[g*TW +: TW];
      m_src[u]   = g;
      m_ptr[u]   = (g + 1) % N;
    end else begin
      m_valid[u] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      g_now[u] = model_grant(u);
      check($sformatf("ready[u%0d]", u), 32'(rdy[u]), (g_now[u] < 0) ? 32'd0 : 32'(1 << g_now[u]));
      check($sformatf("cdb_valid[u%0d]", u), 32'(cv[u]), 32'(m_valid[u]));
      if (m_valid[u]) begin
        check($sformatf("cdb_data[u%0d]", u), cd[u], m_data[u]);
        check($sformatf("cdb_tag[u%0d]", u), 32'(ct[u]), 32'(m_tag[u]));
        check($sformatf("cdb_src[u%0d]", u), 32'(cs[u]), 32'(m_src[u]));
      end
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_clock(u, g_now[u]);
    #1;
  endtask

  // Ungranted valid results keep their payload (and may be squashed); others are fresh.
  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && g_now[0] != i && g_now[1] != i) begin
        req_valid[i] = ($urandom_range(3) != 0);
      end else begin
        req_valid[i]           = 1'($urandom_range(1));
        req_data[i*DW +: DW]   = $urandom;
        req_tag[i*TW +: TW]    = 4'($urandom);
      end
    end
    flush = ($urandom_range(15) == 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '1;
    req_data  = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    req_tag   = {4'd4, 4'd3, 4'd2, 4'd1};
    model_reset();

    #2;
    for (int u = 0; u < 2; u++) begin
      check("reset_ready", 32'(rdy[u]), 32'd0);
      check("reset_valid", 32'(cv[u]), 32'd0);
      check("reset_data", cd[u], 32'd0);
      check("reset_tag", 32'(ct[u]), 32'd0);
      check("reset_src", 32'(cs[u]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_hold_ready", 32'(rdy[u]), 32'd0);
      check("reset_hold_valid", 32'(cv[u]), 32'd0);
    end
    rst_n     = 1'b1;
    req_valid = '0;
    repeat (5) cycle();

    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rotation_ready", 32'(rdy[0]), 32'(1 << (k % 4)));
      cycle();
      check("rotation_tag", 32'(ct[0]), 32'((k % 4) + 1));
    end

    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    req_tag[2*TW +: TW]  = 4'd5;
    #1;
    check("single_ready", 32'(rdy[0]), 32'b0100);
    cycle();
    check("single_valid", 32'(cv[0]), 32'd1);
    check("single_data", cd[0], 32'hDEAD_BEEF);
    check("single_tag", 32'(ct[0]), 32'd5);
    check("single_src", 32'(cs[0]), 32'd2);

    req_valid = 4'b1000;
    cycle();
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 3) check("starve_fu3_granted", 32'(rdy[0]), 32'b1000);
      if (k == 4) check("starve_ptr_wrap", 32'(rdy[0]), 32'b0001);
      cycle();
    end

    req_valid = 4'b0010;
    cycle();
    flush     = 1'b1;
    req_valid = '1;
    #1;
    check("flush_ready_u0", 32'(rdy[0]), 32'd0);
    check("flush_ready_u1", 32'(rdy[1]), 32'd0);
    cycle();
    flush = 1'b0;
    #1;
    check("flush_kill_valid", 32'(cv[0]), 32'd0);
    check("post_flush_rr_u1", 32'(rdy[1]), 32'b0100);
    repeat (3) cycle();

    repeat (300) begin
      rand_inputs();
      cycle();
    end
    flush = 1'b0;

    req_valid = '1;
    cycle();
    check("pre_reset_valid", 32'(cv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("async_reset_ready", 32'(rdy[u]), 32'd0);
      check("async_reset_valid", 32'(cv[u]), 32'd0);
    end
    model_reset();
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("after_reset_lowest_u0", 32'(rdy[0]), 32'b0010);
    check("after_reset_lowest_u1", 32'(rdy[1]), 32'b0010);
    cycle();

    repeat (20) begin
      rand_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
